// File: rtl/fifo_sc_prog_pkg.sv
// Shared constants for the programmable single-clock FIFO: read-mode
// selectors and the depth derivation used by the top and the storage array.
package fifo_sc_prog_pkg;

  localparam int FWFT_REG  = 0;
  localparam int FWFT_FALL = 1;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port, DEPTH x DW, contents are never reset.
module fifo_sc_ram
  import fifo_sc_prog_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sc_prog.sv
// Single-clock FIFO with runtime almost-full/almost-empty thresholds, sticky
// error flags and selectable registered or first-word-fall-through reads.
module fifo_sc_prog
  import fifo_sc_prog_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 4,
  parameter int FWFT = FWFT_REG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  input  logic [AW:0]   af_thresh,
  input  logic [AW:0]   ae_thresh,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH   = fifo_depth(AW);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam bit          IS_FWFT = (FWFT == FWFT_FALL);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_nxt, ram_cnt;
  logic [DW-1:0] ram_q;
  logic          wr_ok, rd_ok, load, ram_re;
  logic          ov, ov_nxt, empty_nxt, rd_seen;

  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  // In FWFT mode rptr addresses the oldest word still in the array; the head
  // word lives in the RAM read register, flagged by ov.
  assign ram_cnt = count - {{AW{1'b0}}, ov};
  assign load    = IS_FWFT && (ram_cnt != '0) && (!ov || rd_ok);
  assign ram_re  = IS_FWFT ? load : rd_ok;

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    ov_nxt = 1'b0;
    if (IS_FWFT) ov_nxt = load ? 1'b1 : (rd_ok ? 1'b0 : ov);
    empty_nxt = IS_FWFT ? !ov_nxt : (count_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      ov           <= 1'b0;
      rd_seen      <= 1'b0;
    end else if (clr) begin
      // rd_seen is kept so a registered-mode dout survives a flush
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      ov           <= 1'b0;
    end else begin
      if (wr_ok)  wptr <= wptr + AW'(1);
      if (ram_re) rptr <= rptr + AW'(1);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= empty_nxt;
      almost_full  <= (count_nxt >= af_thresh);
      almost_empty <= (count_nxt <= ae_thresh);
      if (we & full)  overflow  <= 1'b1;
      if (re & empty) underflow <= 1'b1;
      ov <= ov_nxt;
      if (rd_ok) rd_seen <= 1'b1;
    end
  end

  fifo_sc_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .wen   (wr_ok & rst & ~clr),
    .waddr (wptr),
    .wdata (din),
    .ren   (ram_re & rst & ~clr),
    .raddr (rptr),
    .rdata (ram_q)
  );

  // The RAM register is not reset, so dout is masked until it holds a word.
  assign dout = IS_FWFT ? (ov ? ram_q : '0) : (rd_seen ? ram_q : '0);

endmodule

// File: tb/tb_fifo_sc_prog.sv
// Directed and randomized checks of fifo_sc_prog in registered (index 0) and
// fall-through (index 1) modes, both with AW=2, against a queue model.
module tb_fifo_sc_prog;
  import fifo_sc_prog_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst [2], clr [2], we [2], re [2];
  logic [7:0] din [2], dout [2];
  logic [2:0] aft [2], aet [2], cnt [2];
  logic       full [2], empty [2], af [2], ae [2], ovf [2], udf [2];

  int n_tests = 0;
  int n_fail  = 0;

  fifo_sc_prog #(.DW(8), .AW(2), .FWFT(FWFT_REG)) u_reg (
    .clk(clk), .rst(rst[0]), .clr(clr[0]), .we(we[0]), .din(din[0]), .re(re[0]),
    .dout(dout[0]), .af_thresh(aft[0]), .ae_thresh(aet[0]), .full(full[0]),
    .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
    .overflow(ovf[0]), .underflow(udf[0]));

  fifo_sc_prog #(.DW(8), .AW(2), .FWFT(FWFT_FALL)) u_fwft (
    .clk(clk), .rst(rst[1]), .clr(clr[1]), .we(we[1]), .din(din[1]), .re(re[1]),
    .dout(dout[1]), .af_thresh(aft[1]), .ae_thresh(aet[1]), .full(full[1]),
    .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
    .overflow(ovf[1]), .underflow(udf[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    we[d] = 1'b0; re[d] = 1'b0; clr[d] = 1'b0;
  endtask

  task automatic chk_reset(input int d);
    chk("rst_count", d, 32'(cnt[d]), 0);
    chk("rst_empty", d, 32'(empty[d]), 1);
    chk("rst_ae", d, 32'(ae[d]), 1);
    chk("rst_full", d, 32'(full[d]), 0);
    chk("rst_af", d, 32'(af[d]), 0);
    chk("rst_ovf", d, 32'(ovf[d]), 0);
    chk("rst_udf", d, 32'(udf[d]), 0);
    chk("rst_dout", d, 32'(dout[d]), 0);
  endtask

  task automatic random_run(input int d, input int cycles);
    logic [7:0] q[$];
    logic [7:0] exp_d, w;
    logic       wr, rd;
    exp_d = dout[d];
    clr[d] = 1'b1; step(); clr[d] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      chk("rnd_count", d, 32'(cnt[d]), q.size());
      chk("rnd_full", d, 32'(full[d]), 32'(q.size() == DEPTH));
      chk("rnd_af", d, 32'(af[d]), 32'(q.size() >= 3));
      chk("rnd_ae", d, 32'(ae[d]), 32'(q.size() <= 1));
      chk("rnd_bound", d, 32'(cnt[d] <= 3'(DEPTH)), 1);
      if (d == 0) begin
        chk("rnd_empty", d, 32'(empty[d]), 32'(q.size() == 0));
        chk("rnd_dout", d, 32'(dout[d]), 32'(exp_d));
      end else begin
        if (q.size() == 0) chk("rnd_empty", d, 32'(empty[d]), 1);
        if (!empty[d] && q.size() > 0) chk("rnd_head", d, 32'(dout[d]), 32'(q[0]));
      end
      w = 8'($urandom);
      we[d] = ($urandom_range(0, 99) < ((c < cycles / 2) ? 65 : 35));
      re[d] = ($urandom_range(0, 99) < ((c < cycles / 2) ? 35 : 65));
      din[d] = w;
      wr = we[d] && (q.size() < DEPTH);
      rd = re[d] && ((d == 0) ? (q.size() > 0) : !empty[d]);
      @(posedge clk);
      if (rd) exp_d = q.pop_front();
      if (wr) q.push_back(w);
      @(negedge clk);
    end
    idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; idle(d); din[d] = '0; aft[d] = 3'd3; aet[d] = 3'd1;
    end
    step(); step();
    chk_reset(0);
    chk_reset(1);
    rst[0] = 1'b1; rst[1] = 1'b1;
    step();

    // Registered mode: fill, overflow, drain with one-cycle latency
    for (int i = 0; i < 4; i++) begin
      we[0] = 1'b1; din[0] = 8'hA1 + 8'(i); step();
    end
    we[0] = 1'b0;
    chk("fill_full", 0, 32'(full[0]), 1);
    chk("fill_count", 0, 32'(cnt[0]), 4);
    we[0] = 1'b1; din[0] = 8'hEE; step(); we[0] = 1'b0;
    chk("ovf_set", 0, 32'(ovf[0]), 1);
    chk("ovf_count", 0, 32'(cnt[0]), 4);
    for (int i = 0; i < 4; i++) begin
      re[0] = 1'b1; step();
      chk("drain_dout", 0, 32'(dout[0]), 32'(8'hA1 + 8'(i)));
    end
    re[0] = 1'b0;
    chk("drain_empty", 0, 32'(empty[0]), 1);
    chk("drain_count", 0, 32'(cnt[0]), 0);
    step();
    chk("hold_dout", 0, 32'(dout[0]), 32'hA4);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    chk("clr_ovf", 0, 32'(ovf[0]), 0);

    // Threshold flags while filling, then a runtime threshold change
    for (int k = 0; k <= 4; k++) begin
      chk("thr_ae", 0, 32'(ae[0]), 32'(k <= 1));
      chk("thr_af", 0, 32'(af[0]), 32'(k >= 3));
      if (k == 2) begin
        aft[0] = 3'd2; step();
        chk("thr_af_change", 0, 32'(af[0]), 1);
        aft[0] = 3'd3; step();
        chk("thr_af_restore", 0, 32'(af[0]), 0);
      end
      if (k < 4) begin
        we[0] = 1'b1; din[0] = 8'h10 + 8'(k); step(); we[0] = 1'b0;
      end
    end

    // Simultaneous push/pop at full and at empty
    we[0] = 1'b1; re[0] = 1'b1; din[0] = 8'h77; step(); idle(0);
    chk("full_wr_rd_count", 0, 32'(cnt[0]), 3);
    chk("full_wr_rd_ovf", 0, 32'(ovf[0]), 1);
    chk("full_wr_rd_dout", 0, 32'(dout[0]), 32'h10);
    for (int i = 0; i < 3; i++) begin
      re[0] = 1'b1; step();
      chk("drain2_dout", 0, 32'(dout[0]), 32'(8'h11 + 8'(i)));
    end
    re[0] = 1'b0;
    we[0] = 1'b1; re[0] = 1'b1; din[0] = 8'h99; step(); idle(0);
    chk("empty_wr_rd_count", 0, 32'(cnt[0]), 1);
    chk("empty_wr_rd_udf", 0, 32'(udf[0]), 1);
    re[0] = 1'b1; step(); re[0] = 1'b0;
    chk("empty_wr_rd_dout", 0, 32'(dout[0]), 32'h99);

    // Flush beats a same-cycle write; dout survives it
    for (int i = 0; i < 3; i++) begin
      we[0] = 1'b1; din[0] = 8'h30 + 8'(i); step();
    end
    clr[0] = 1'b1; din[0] = 8'h3F; step(); idle(0);
    chk("clr_count", 0, 32'(cnt[0]), 0);
    chk("clr_empty", 0, 32'(empty[0]), 1);
    chk("clr_ovf2", 0, 32'(ovf[0]), 0);
    chk("clr_udf", 0, 32'(udf[0]), 0);
    chk("clr_dout", 0, 32'(dout[0]), 32'h99);
    step();
    chk("clr_nowrite", 0, 32'(cnt[0]), 0);

    // Reset in the middle of a fill
    for (int i = 0; i < 2; i++) begin
      we[0] = 1'b1; din[0] = 8'h40 + 8'(i); step();
    end
    rst[0] = 1'b0; re[0] = 1'b1; step(); rst[0] = 1'b1; idle(0);
    chk_reset(0);

    // Fall-through mode: latency to first word and back-to-back pops
    we[1] = 1'b1; din[1] = 8'h55; step(); we[1] = 1'b0;
    chk("fwft_empty_c1", 1, 32'(empty[1]), 1);
    chk("fwft_count_c1", 1, 32'(cnt[1]), 1);
    step();
    chk("fwft_empty_c2", 1, 32'(empty[1]), 0);
    chk("fwft_dout_c2", 1, 32'(dout[1]), 32'h55);
    for (int i = 0; i < 2; i++) begin
      we[1] = 1'b1; din[1] = 8'h56 + 8'(i); step();
    end
    we[1] = 1'b0;
    chk("fwft_count3", 1, 32'(cnt[1]), 3);
    for (int i = 0; i < 3; i++) begin
      chk("fwft_b2b_empty", 1, 32'(empty[1]), 0);
      chk("fwft_b2b_dout", 1, 32'(dout[1]), 32'(8'h55 + 8'(i)));
      re[1] = 1'b1; step();
    end
    re[1] = 1'b0;
    chk("fwft_drained", 1, 32'(empty[1]), 1);
    chk("fwft_drained_cnt", 1, 32'(cnt[1]), 0);

    random_run(0, 64);
    random_run(1, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sc_prog.md
FIFO_SC_PROG -- requirements
Module: fifo_sc_prog

Interface
REQ-001 SHALL have parameter DW, 8, data width in bits (>=1).
REQ-002 SHALL have parameter AW, 4, address width; DEPTH = 2**AW entries, all usable (AW>=2).
REQ-003 SHALL have parameter FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port clr  in  1  synchronous flush.
REQ-007 SHALL have port we, din  in  1, DW  write request, write data.
REQ-008 SHALL have port re  in  1  read request (pop).
REQ-009 SHALL have port dout  out  DW  read data.
REQ-010 SHALL have port af_thresh, ae_thresh  in  AW+1 each  runtime almost-full / almost-empty thresholds.
REQ-011 SHALL have port full, empty, almost_full, almost_empty  out  1 each  registered status flags.
REQ-012 SHALL have port count  out  AW+1  registered occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow, underflow  out  1 each  sticky error flags.

Function
REQ-014 Accepted write wr_ok = we & !full; accepted read rd_ok = re & !empty; both use the current registered flags.
REQ-015 Rejected write (we & full) SHALL leave memory, pointers and count unchanged, and SHALL set overflow; rejected read (re & empty) SHALL set underflow.
REQ-016 Write and read pointers SHALL be AW bits, advance by 1 on accept, wrap DEPTH-1 -> 0 with no gap.
REQ-017 count SHALL be +1 on wr_ok only, -1 on rd_ok only, and unchanged on both or neither.
REQ-018 All four flags SHALL be computed from next-count and registered, so they are valid in the same cycle as count: full = (count==DEPTH); empty = (count==0) when FWFT=0; almost_full = (count>=af_thresh); almost_empty = (count<=ae_thresh).
REQ-019 At full, simultaneous we & re: read accepted, write rejected, overflow set, count becomes DEPTH-1.
REQ-020 At empty, simultaneous we & re: write accepted, read rejected, underflow set, count becomes 1.
REQ-021 FWFT=0: on rd_ok, dout SHALL present the head word one cycle later; otherwise dout holds its value.
REQ-022 FWFT=0: empty deasserts the cycle after the first accepted write.
REQ-023 FWFT=1: a single output register SHALL hold the head word. empty = !(output register valid). dout is valid whenever empty=0. rd_ok pops the head word; the next word SHALL be shown in the following cycle if present, with no bubble.
REQ-024 FWFT=1: a write into an empty FIFO SHALL deassert empty 2 cycles after acceptance. count includes the output-register word. Total capacity is DEPTH.
REQ-025 clr SHALL take priority over we/re in the same cycle and SHALL:
  - zero the pointers and count;
  - set empty=1, almost_empty=1, full=0, almost_full=0;
  - clear overflow and underflow;
  - invalidate the FWFT output register.
  With FWFT=0, clr SHALL leave dout unchanged.
REQ-026 Threshold changes SHALL take effect on the flags at the next registered update.

Reset
REQ-027 While rst=0 at a clock edge, SHALL set: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0, FWFT valid=0.
REQ-028 Reset mid-operation SHALL discard all stored words. Memory contents need not be cleared.
REQ-029 Reset SHALL override clr, we and re.

Structure
REQ-030 A shared package SHALL hold the FWFT mode constants and the DEPTH derivation function.
REQ-031 Storage SHALL be one sub-module, fifo_sc_ram: 1 write port, 1 synchronous read port, DEPTH x DW, no reset.
REQ-032 Pointers, count, flags, error flags and the FWFT prefetch SHALL reside in fifo_sc_prog.

Verification
REQ-033 AW=2, FWFT=0:
  - write 4 words 0xA1..0xA4 -> full=1, count=4;
  - a 5th write -> overflow=1, count=4;
  - 4 reads -> dout 0xA1..0xA4, each one cycle after re; empty=1.
REQ-034 FWFT=1: write 0x55 to empty -> empty=0 two cycles later with dout=0x55. Then back-to-back re with 3 words queued -> 3 consecutive distinct words, no bubble.
REQ-035 af_thresh=3, ae_thresh=1:
  - fill 0->4 -> almost_empty=1 at count 0,1; almost_full=1 at count 3,4;
  - change af_thresh to 2 at count 2 -> almost_full=1 next cycle.
REQ-036 At full, we & re -> count=DEPTH-1, overflow=1, head word read. At empty, we & re -> count=1, underflow=1.
REQ-037 clr with count=3 and we=1 -> count=0, empty=1, overflow/underflow cleared, no write stored. Reset mid-fill -> all reset values per REQ-027.
REQ-038 Wrap test, FWFT=0 and FWFT=1: 3*DEPTH random push/pop -> data order matches a reference queue; count never exceeds DEPTH.
